// File: rtl/prf_scoreboard.sv
// Physical register file with per-register ready bits.
// Multi-port read/write/allocate, optional bypass and registered reads.
module prf_scoreboard #(
  parameter int R_PORTS  = 4,
  parameter int W_PORTS  = 4,
  parameter int A_PORTS  = 2,
  parameter int PRN_BITS = 6,
  parameter int DATA_W   = 64,
  parameter int BYPASS   = 1,
  parameter int RD_REG   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [R_PORTS-1:0]           ren,
  input  logic [R_PORTS*PRN_BITS-1:0]  rprn,
  output logic [R_PORTS*DATA_W-1:0]    rdata,
  output logic [R_PORTS-1:0]           rready,
  input  logic [W_PORTS-1:0]           wen,
  input  logic [W_PORTS*PRN_BITS-1:0]  wprn,
  input  logic [W_PORTS*DATA_W-1:0]    wdata,
  input  logic [A_PORTS-1:0]           aen,
  input  logic [A_PORTS*PRN_BITS-1:0]  aprn,
  output logic                         wcollide
);

  localparam int DEPTH = 2**PRN_BITS;

  logic [DATA_W-1:0]         regs [DEPTH];
  logic [DEPTH-1:0]          rdy;
  logic                      collide;
  logic [R_PORTS*DATA_W-1:0] rd_d;
  logic [R_PORTS-1:0]        rd_r;

  // Two enabled writes hitting the same non-zero PRN
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < W_PORTS; i++) begin
      for (int j = i + 1; j < W_PORTS; j++) begin
        if (wen[i] && wen[j] &&
            wprn[i*PRN_BITS +: PRN_BITS] ==
            wprn[j*PRN_BITS +: PRN_BITS] &&
            wprn[i*PRN_BITS +: PRN_BITS] != '0)
          collide = 1'b1;
      end
    end
  end

  // Register/ready update: later write channels override, allocate wins last
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < DEPTH; p++)
        regs[p] <= '0;
      rdy      <= '1;
      wcollide <= 1'b0;
    end else begin
      for (int i = 0; i < W_PORTS; i++) begin
        if (wen[i] && wprn[i*PRN_BITS +: PRN_BITS] != '0) begin
          regs[wprn[i*PRN_BITS +: PRN_BITS]] <=
            wdata[i*DATA_W +: DATA_W];
          rdy[wprn[i*PRN_BITS +: PRN_BITS]] <= 1'b1;
        end
      end
      for (int k = 0; k < A_PORTS; k++) begin
        if (aen[k] && aprn[k*PRN_BITS +: PRN_BITS] != '0)
          rdy[aprn[k*PRN_BITS +: PRN_BITS]] <= 1'b0;
      end
      wcollide <= collide;
    end
  end

  // Read lookup with optional same-cycle write forwarding
  always_comb begin
    rd_d = '0;
    rd_r = '0;
    for (int r = 0; r < R_PORTS; r++) begin
      if (ren[r]) begin
        if (rprn[r*PRN_BITS +: PRN_BITS] == '0) begin
          rd_r[r] = 1'b1;
        end else begin
          rd_d[r*DATA_W +: DATA_W] =
            regs[rprn[r*PRN_BITS +: PRN_BITS]];
          rd_r[r] = rdy[rprn[r*PRN_BITS +: PRN_BITS]];
          if (BYPASS != 0) begin
            for (int w = 0; w < W_PORTS; w++) begin
              if (wen[w] &&
                  wprn[w*PRN_BITS +: PRN_BITS] ==
                  rprn[r*PRN_BITS +: PRN_BITS]) begin
                rd_d[r*DATA_W +: DATA_W] =
                  wdata[w*DATA_W +: DATA_W];
                rd_r[r] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  if (RD_REG != 0) begin : g_reg
    // One-cycle registered read outputs
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdata  <= '0;
        rready <= '0;
      end else begin
        rdata  <= rd_d;
        rready <= rd_r;
      end
    end
  end else begin : g_comb
    assign rdata  = rd_d;
    assign rready = rd_r;
  end

endmodule

// File: tb/tb_prf_scoreboard.sv
// Bench for prf_scoreboard: combinational/bypass and
// registered/no-bypass instances driven from shared stimulus.
module tb_prf_scoreboard;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   ren;
  logic [23:0]  rprn;
  logic [3:0]   wen;
  logic [23:0]  wprn;
  logic [255:0] wdata;
  logic [1:0]   aen;
  logic [11:0]  aprn;

  logic [255:0] rdata_c, rdata_r;
  logic [3:0]   rready_c, rready_r;
  logic         wcol_c, wcol_r;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    int          dut;
    int          kind;
    int          ch;
    logic [63:0] d;
    logic        r;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t ce;

  prf_scoreboard u_comb (
    .clk(clk), .rst_n(rst_n),
    .ren(ren), .rprn(rprn),
    .rdata(rdata_c), .rready(rready_c),
    .wen(wen), .wprn(wprn), .wdata(wdata),
    .aen(aen), .aprn(aprn),
    .wcollide(wcol_c)
  );

  prf_scoreboard #(.BYPASS(0), .RD_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n),
    .ren(ren), .rprn(rprn),
    .rdata(rdata_r), .rready(rready_r),
    .wen(wen), .wprn(wprn), .wdata(wdata),
    .aen(aen), .aprn(aprn),
    .wcollide(wcol_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Pop every expectation due this cycle and compare
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        ce = sb[i];
        sb.delete(i);
        if (ce.kind == 1) begin
          chk(ce.tag, {63'd0, (ce.dut == 0) ? wcol_c : wcol_r},
              {63'd0, ce.r});
        end else if (ce.dut == 0) begin
          chk({ce.tag, "_d"}, rdata_c[ce.ch*64 +: 64], ce.d);
          chk({ce.tag, "_r"}, {63'd0, rready_c[ce.ch]},
              {63'd0, ce.r});
        end else begin
          chk({ce.tag, "_D"}, rdata_r[ce.ch*64 +: 64], ce.d);
          chk({ce.tag, "_R"}, {63'd0, rready_r[ce.ch]},
              {63'd0, ce.r});
        end
      end
    end
  end

  task automatic push(input string tag, input int dut,
                      input int kind, input int ch,
                      input logic [63:0] d, input logic r,
                      input int due);
    exp_t e;
    e.tag = tag; e.dut = dut; e.kind = kind; e.ch = ch;
    e.d = d; e.r = r; e.due = due;
    sb.push_back(e);
  endtask

  task automatic ec(input string tag, input int ch,
                    input logic [63:0] d, input logic r);
    push(tag, 0, 0, ch, d, r, cyc);
  endtask

  task automatic er(input string tag, input int ch,
                    input logic [63:0] d, input logic r,
                    input int lat);
    push(tag, 1, 0, ch, d, r, cyc + lat);
  endtask

  task automatic wc(input string tag, input logic v);
    push({tag, "_c"}, 0, 1, 0, '0, v, cyc);
    push({tag, "_r"}, 1, 1, 0, '0, v, cyc);
  endtask

  task automatic clr();
    ren = '0; rprn = '0;
    wen = '0; wprn = '0; wdata = '0;
    aen = '0; aprn = '0;
  endtask

  task automatic rd(input int ch, input logic [5:0] p);
    ren[ch] = 1'b1;
    rprn[ch*6 +: 6] = p;
  endtask

  task automatic wr(input int ch, input logic [5:0] p,
                    input logic [63:0] d);
    wen[ch] = 1'b1;
    wprn[ch*6 +: 6] = p;
    wdata[ch*64 +: 64] = d;
  endtask

  task automatic al(input int ch, input logic [5:0] p);
    aen[ch] = 1'b1;
    aprn[ch*6 +: 6] = p;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    wr(0, 6'd5, 64'h77);
    al(0, 6'd6);
    @(posedge clk);
    @(posedge clk);
    #1;
    clr();
    rst_n = 1'b1;
    // Reset state; writes/allocs during reset discarded
    rd(0, 6'd5); rd(1, 6'd6);
    ec("rst_r5", 0, 64'h0, 1'b1);
    ec("rst_r6", 1, 64'h0, 1'b1);
    er("rst_out", 0, 64'h0, 1'b0, 0);
    er("rst_r5", 0, 64'h0, 1'b1, 1);
    wc("rst_wcol", 1'b0);

    next();
    al(0, 6'd7); rd(0, 6'd7);
    ec("pre_alloc7", 0, 64'h0, 1'b1);

    next();
    rd(0, 6'd7);
    ec("alloc7", 0, 64'h0, 1'b0);
    er("alloc7", 0, 64'h0, 1'b0, 1);

    next();
    wr(0, 6'd7, 64'hDEAD_BEEF);
    rd(0, 6'd7); rd(1, 6'd7);
    ec("byp7", 0, 64'hDEAD_BEEF, 1'b1);
    ec("byp7b", 1, 64'hDEAD_BEEF, 1'b1);
    er("nobyp7", 0, 64'h0, 1'b0, 1);

    next();
    rd(0, 6'd7);
    ec("st7", 0, 64'hDEAD_BEEF, 1'b1);
    er("st7", 0, 64'hDEAD_BEEF, 1'b1, 1);

    next();
    wr(0, 6'd3, 64'h11); wr(2, 6'd3, 64'h22);
    rd(2, 6'd3);
    ec("byp3", 2, 64'h22, 1'b1);
    wc("wcol_pre", 1'b0);

    next();
    rd(0, 6'd3);
    ec("col3", 0, 64'h22, 1'b1);
    er("col3", 0, 64'h22, 1'b1, 1);
    wc("wcol_hit", 1'b1);

    next();
    wr(1, 6'd9, 64'h5); al(1, 6'd9);
    rd(3, 6'd9);
    ec("byp9", 3, 64'h5, 1'b1);
    wc("wcol_drop", 1'b0);

    next();
    rd(0, 6'd9);
    ec("wa9", 0, 64'h5, 1'b0);
    er("wa9", 0, 64'h5, 1'b0, 1);

    next();
    wr(0, 6'd0, 64'hFF); wr(1, 6'd0, 64'hEE);
    wr(2, 6'd0, 64'hDD); al(0, 6'd0);
    rd(0, 6'd0);
    ec("z0", 0, 64'h0, 1'b1);
    ec("off1", 1, 64'h0, 1'b0);
    er("z0", 0, 64'h0, 1'b1, 1);

    next();
    rd(0, 6'd0);
    ec("z0b", 0, 64'h0, 1'b1);
    wc("wcol_z0", 1'b0);

    next();
    wr(0, 6'd4, 64'hA); rd(0, 6'd4);
    ec("byp4", 0, 64'hA, 1'b1);
    er("old4", 0, 64'h0, 1'b1, 1);

    next();
    rd(0, 6'd4);
    ec("st4", 0, 64'hA, 1'b1);
    er("new4", 0, 64'hA, 1'b1, 1);

    next();
    rst_n = 1'b0;
    rd(0, 6'd4);
    wr(0, 6'd4, 64'hB); wr(1, 6'd4, 64'hC);
    al(0, 6'd10);
    ec("rstcyc", 0, 64'hC, 1'b1);

    next();
    rst_n = 1'b1;
    rd(0, 6'd4); rd(1, 6'd10);
    ec("post4", 0, 64'h0, 1'b1);
    ec("post10", 1, 64'h0, 1'b1);
    er("rst_mid0", 0, 64'h0, 1'b0, 0);
    er("rst_mid1", 1, 64'h0, 1'b0, 0);
    er("post4", 0, 64'h0, 1'b1, 1);
    wc("wcol_rst", 1'b0);

    next();
    ec("idle", 0, 64'h0, 1'b0);

    next();
    next();
    chk("sb_drain", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
